// File: rtl/log_arbiter.sv
// log_arbiter: round-robin arbiter that funnels level-tagged event records from
// NB_REQ requesters into one log sink through a single-entry output buffer.
// Records whose level is below cfg_min_level are accepted but discarded and
// counted in drop_count.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   cfg_min_level[2:0]   minimum forwarded level (0 forwards everything)
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_level, req_event packed per-requester record fields
//   log_valid/log_ready  output handshake
//   log_id/level/event   buffered record, log_time = timestamp at acceptance
//   drop_count[15:0]     saturating count of filtered records
module log_arbiter #(
  parameter int unsigned  NB_REQ = 4,
  parameter int unsigned  EVT_W  = 8,
  parameter int unsigned  TS_W   = 16,
  localparam int unsigned ID_W   = $clog2(NB_REQ)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [2:0]              cfg_min_level,
  input  logic [NB_REQ-1:0]       req_valid,
  output logic [NB_REQ-1:0]       req_ready,
  input  logic [NB_REQ*3-1:0]     req_level,
  input  logic [NB_REQ*EVT_W-1:0] req_event,
  output logic                    log_valid,
  input  logic                    log_ready,
  output logic [ID_W-1:0]         log_id,
  output logic [2:0]              log_level,
  output logic [EVT_W-1:0]        log_event,
  output logic [TS_W-1:0]         log_time,
  output logic [15:0]             drop_count
);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [2:0]        level_q, level_d;
  logic [EVT_W-1:0]  event_q, event_d;
  logic [TS_W-1:0]   time_q, time_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [15:0]       drop_q, drop_d;

  logic              window;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  logic [2:0]        gnt_level;
  logic [EVT_W-1:0]  gnt_event;

  // Rotating priority done as two ascending passes: first indices at or above
  // ptr, then the wrapped-around ones below it. Equivalent to a search from
  // ptr upward modulo NB_REQ, without variable-index selects.
  always_comb begin
    window  = aresetn && ((state_q == ST_EMPTY) || log_ready);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (window) begin
      for (int unsigned k = 0; k < NB_REQ; k++) begin
        if (!gnt_vld && req_valid[k] && (32'(ptr_q) <= k)) begin
          gnt_vld = 1'b1;
          gnt_idx = ID_W'(k);
        end
      end
      for (int unsigned k = 0; k < NB_REQ; k++) begin
        if (!gnt_vld && req_valid[k] && (32'(ptr_q) > k)) begin
          gnt_vld = 1'b1;
          gnt_idx = ID_W'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_level = '0;
    gnt_event = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      if (gnt_idx == ID_W'(k)) begin
        gnt_level = req_level[k*3 +: 3];
        gnt_event = req_event[k*EVT_W +: EVT_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    level_d   = level_q;
    event_d   = event_q;
    time_d    = time_q;
    drop_d    = drop_q;
    ts_d      = ts_q + 1'b1;
    req_ready = '0;
    if (gnt_vld) begin
      req_ready = NB_REQ'(1) << gnt_idx;
      ptr_d     = (gnt_idx == ID_W'(NB_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (gnt_level >= cfg_min_level) begin
        state_d = ST_HOLD;
        id_d    = gnt_idx;
        level_d = gnt_level;
        event_d = gnt_event;
        time_d  = ts_q;
      end else begin
        // A grant only happens with the buffer empty or draining, so a drop
        // always leaves it empty.
        state_d = ST_EMPTY;
        drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
      end
    end else if ((state_q == ST_HOLD) && log_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      level_q <= '0;
      event_q <= '0;
      time_q  <= '0;
      ts_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      level_q <= level_d;
      event_q <= event_d;
      time_q  <= time_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
    end
  end

  assign log_valid  = (state_q == ST_HOLD);
  assign log_id     = id_q;
  assign log_level  = level_q;
  assign log_event  = event_q;
  assign log_time   = time_q;
  assign drop_count = drop_q;

endmodule
